ifft4_seq: RTL and testbench



---
 rtl/ifft4_seq_if.sv | 21 ++
 rtl/ifft4_seq.sv | 135 +++++++++++++
 tb/tb_ifft4_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifft4_seq_if.sv
// Bin-beat input stream and recovered-word output stream for ifft4_seq.
interface ifft4_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_re;
    logic [2:0] in_im;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_bits;
    logic       out_err;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_bits, out_err
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_bits, out_err
    );
endinterface

// File: rtl/ifft4_seq.sv
// Sequential 4-point inverse FFT: loads four fft2 bins, rebuilds the four
// binary samples one per cycle and flags spectra that are not legal fft2 output.
module ifft4_seq (
    input  logic         clk,
    input  logic         rst,
    ifft4_seq_if.slave   bus
);
    localparam int unsigned FLD_W = 3;
    localparam int unsigned ACC_W = 7;
    localparam int unsigned N_BIN = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [FLD_W-1:0]        re_q [N_BIN];
    logic [FLD_W-1:0]        im_q [N_BIN];
    logic [IDX_W-1:0]        beat_q;
    logic [IDX_W-1:0]        n_q;
    logic [N_BIN-1:0]        bits_q;
    logic                    err_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    in_ready_d;
    logic                    out_valid_d;

    logic                    in_fire;
    logic signed [ACC_W-1:0] r0, r1, i1, r2;
    logic signed [ACC_W-1:0] acc;
    logic                    sample_err;
    logic                    spec_err;

    assign in_fire       = bus.in_valid & in_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bits  = bits_q;
    assign bus.out_err   = err_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (in_fire && (beat_q == 2'd3)) state_d = CALC;
            CALC:    if (n_q == 2'd3)                 state_d = OUT;
            OUT:     if (bus.out_ready)               state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Handshake flags are decodes of the next state, registered below
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        case (state_d)
            LOAD:    in_ready_d  = 1'b1;
            OUT:     out_valid_d = 1'b1;
            default: ;
        endcase
    end

    // R0 is unsigned 0..4; the other used fields are two's complement
    always_comb begin
        r0 = ACC_W'({4'b0000, re_q[0]});
        r1 = ACC_W'({{4{re_q[1][2]}}, re_q[1]});
        i1 = ACC_W'({{4{im_q[1][2]}}, im_q[1]});
        r2 = ACC_W'({{4{re_q[2][2]}}, re_q[2]});
        acc = r0 + r2 + (r1 <<< 1);
        case (n_q)
            2'd0:    acc = r0 + r2 + (r1 <<< 1);
            2'd1:    acc = r0 - r2 - (i1 <<< 1);
            2'd2:    acc = r0 + r2 - (r1 <<< 1);
            2'd3:    acc = r0 - r2 + (i1 <<< 1);
            default: ;
        endcase
        sample_err = (acc != ACC_W'(0)) && (acc != ACC_W'(4));
        spec_err   = (im_q[0] != FLD_W'(0)) || (im_q[2] != FLD_W'(0)) ||
                     (re_q[3] != re_q[1]) ||
                     (im_q[3] != FLD_W'(FLD_W'(0) - im_q[1]));
    end

    // Handshake flags, bin storage and per-sample accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            beat_q      <= '0;
            n_q         <= '0;
            bits_q      <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < N_BIN; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            case (state_q)
                LOAD: begin
                    if (in_fire) begin
                        re_q[beat_q] <= bus.in_re;
                        im_q[beat_q] <= bus.in_im;
                        beat_q       <= beat_q + IDX_W'(1);
                    end
                end
                CALC: begin
                    bits_q[n_q] <= acc[2];
                    err_q       <= err_q | sample_err | ((n_q == 2'd0) & spec_err);
                    n_q         <= n_q + IDX_W'(1);
                end
                OUT: begin
                    if (bus.out_ready) begin
                        beat_q <= '0;
                        n_q    <= '0;
                        bits_q <= '0;
                        err_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ifft4_seq.sv
// Scoreboard bench for ifft4_seq: frames built by a forward fft2 model,
// expectations queued at send time and checked on each output handshake.
module tb_ifft4_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ifft4_seq_if bus();

    ifft4_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] bits;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   n_sent  = 0;
    int   n_out   = 0;
    int   beats   = 0;
    int   lat     = 0;
    bit   busy    = 1'b0;
    bit   seen    = 1'b0;
    bit   stall_on = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Forward 4-point FFT of a binary word, packed as {I3,R3,I2,R2,I1,R1,I0,R0}
    function automatic logic [23:0] fft2(input logic [3:0] x);
        int x0, x1, x2, x3;
        logic [23:0] f;
        x0 = int'(x[0]); x1 = int'(x[1]); x2 = int'(x[2]); x3 = int'(x[3]);
        f = '0;
        f[2:0]   = 3'(x0 + x1 + x2 + x3);
        f[8:6]   = 3'(x0 - x2);
        f[11:9]  = 3'(x3 - x1);
        f[14:12] = 3'(x0 - x1 + x2 - x3);
        f[20:18] = 3'(x0 - x2);
        f[23:21] = 3'(x1 - x3);
        return f;
    endfunction

    task automatic send_beats(input logic [23:0] f, input int nbeats, input int max_gap);
        int  g;
        int  tmo;
        logic acc;
        for (int k = 0; k < nbeats; k++) begin
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            bus.in_valid = 1'b0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_re    = f[6*k +: 3];
            bus.in_im    = f[6*k+3 +: 3];
            tmo = 0;
            acc = 1'b0;
            while (!acc && tmo < 200) begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk);
                #1;
                tmo++;
            end
            if (!acc) chk("beat_accept", int'(acc), 1);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [23:0] f, input logic [3:0] eb, input logic ee,
                             input int max_gap);
        exp_t e;
        e.bits = eb;
        e.err  = ee;
        exp_q.push_back(e);
        n_sent++;
        send_beats(f, 4, max_gap);
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready",  int'(bus.in_ready),  1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_bits",  int'(bus.out_bits),  0);
        chk("rst_out_err",   int'(bus.out_err),   0);
    endtask

    task automatic drain();
        int tmo;
        tmo = 0;
        while ((exp_q.size() != 0 || busy) && tmo < 500) begin
            @(posedge clk);
            #1;
            tmo++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Downstream ready: always high, or random 0-5 cycle stalls per word
    initial begin
        int stall_left;
        stall_left    = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!stall_on) begin
                bus.out_ready = 1'b1;
            end else if (bus.out_valid) begin
                if (stall_left > 0) begin
                    bus.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end else begin
                bus.out_ready = 1'b0;
                stall_left    = int'($urandom_range(0, 5));
            end
        end
    end

    // Monitor: latency, in_ready low while busy, and scoreboard compare
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            beats = 0;
            busy  = 1'b0;
            seen  = 1'b0;
            lat   = 0;
        end else begin
            if (busy) begin
                lat++;
                chk("in_ready_busy", int'(bus.in_ready), 0);
                if (bus.out_valid && !seen) begin
                    seen = 1'b1;
                    chk("latency", lat, 5);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                busy = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("spurious_out", int'(bus.out_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_bits", int'(bus.out_bits), int'(e.bits));
                    chk("out_err",  int'(bus.out_err),  int'(e.err));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                beats++;
                if (beats == 4) begin
                    beats = 0;
                    busy  = 1'b1;
                    lat   = 0;
                    seen  = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [23:0] f;
        bus.in_valid = 1'b0;
        bus.in_re    = '0;
        bus.in_im    = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed frames, no gaps, ready held high
        run_frame(24'd0, 4'b0000, 1'b0, 0);
        run_frame(24'd4, 4'b1111, 1'b0, 0);
        f = '0; f[2:0] = 3'd2; f[14:12] = 3'd2;
        run_frame(f, 4'b0101, 1'b0, 0);
        f = '0; f[2:0] = 3'd1; f[11:9] = 3'b111; f[14:12] = 3'b111; f[23:21] = 3'd1;
        run_frame(f, 4'b0010, 1'b0, 0);
        drain();

        // Exhaustive sweep with input gaps and output stalls
        stall_on = 1'b1;
        for (int i = 0; i < 16; i++) begin
            run_frame(fft2(4'(i)), 4'(i), 1'b0, 3);
        end
        drain();
        stall_on = 1'b0;

        // Illegal spectra
        f = fft2(4'b0110); f[5:3] = 3'd1;
        run_frame(f, 4'b0110, 1'b1, 0);
        f = fft2(4'b1011); f[20:18] = f[20:18] + 3'd1;
        run_frame(f, 4'b1011, 1'b1, 0);
        f = '0; f[2:0] = 3'd3;
        run_frame(f, 4'b0000, 1'b1, 0);
        f = fft2(4'b0001); f[17:15] = 3'd1;
        run_frame(f, 4'b0001, 1'b1, 0);
        drain();

        // Abort after bin 2, then a fresh frame
        send_beats(fft2(4'b0111), 3, 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame(fft2(4'b1001), 4'b1001, 1'b0, 0);
        drain();

        repeat (5) @(posedge clk);
        chk("frames_out", n_out, n_sent);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
